obi_axil_master: RTL and testbench
==================================

// Module: obi_axil_master
// PURPOSE
//  Bus initiator bridging the core's OBI-style data port to AXI4-Lite master channels (AW/W/B/AR/R).
//  Feeds the interconnect that reaches peripheral slaves (GPIO, timers, UART).
//  One outstanding transaction; each OBI request becomes exactly one AXI-Lite read or write.
// PARAMETERS
//  ADDR_W     32           address width, OBI and AXI
//  DATA_W     32           data width (fixed at 32; strobe width 4)
//  ADDR_BASE  32'h2000_0000  legal window base (used only with AXIL_MST_ADDR_CHECK_EN)
//  ADDR_MASK  32'hFFFF_0000  window compare mask (used only with AXIL_MST_ADDR_CHECK_EN)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   asynchronous reset, active-high
//  req_i      in   1   OBI request
//  gnt_o      out  1   OBI grant (combinational)
//  addr_i     in   32  OBI address
//  we_i       in   1   1=write 0=read
//  be_i       in   4   byte enables -> wstrb
//  wdata_i    in   32  write data
//  rvalid_o   out  1   OBI response valid, one-cycle pulse
//  rdata_o    out  32  read data, valid with rvalid_o
//  err_o      out  1   response error, valid with rvalid_o
//  m_awaddr/m_awvalid out 32/1; m_awready in 1   AW channel
//  m_wdata/m_wstrb/m_wvalid out 32/4/1; m_wready in 1   W channel
//  m_bresp in 2; m_bvalid in 1; m_bready out 1   B channel
//  m_araddr/m_arvalid out 32/1; m_arready in 1   AR channel
//  m_rdata in 32; m_rresp in 2; m_rvalid in 1; m_rready out 1   R channel
// BEHAVIOUR
//  Reset: state=IDLE; all *valid/*ready outputs, rvalid_o and err_o =0; rdata_o, address and data regs =0.
//   Reset mid-transaction drops all valids immediately; no response is issued.
//  FSM: IDLE, WR (AW+W), WB (wait B), RA (AR), RR (wait R), RSP.
//  IDLE: gnt_o=req_i. On req_i&gnt_o: latch addr/we/be/wdata; go to WR if we_i, else RA.
//   gnt_o=0 in every other state.
//  WR: m_awvalid and m_wvalid are asserted on entry and each is held until its own handshake.
//   aw_done/w_done flags are tracked separately; either order or the same cycle is accepted.
//   When both are done, go to WB.
//   A valid is never dropped before its ready, and addr/data stay stable while valid.
//  WB: m_bready=1 only in this state. On m_bvalid: err=(m_bresp!=2'b00), rdata=0, go to RSP.
//   An early m_bvalid waits, which is legal.
//  RA: m_arvalid=1 until m_arready. RR: m_rready=1; on m_rvalid capture m_rdata and err=(m_rresp!=0).
//  RSP: rvalid_o=1 for exactly one cycle; rdata_o/err_o held until the next response; then IDLE.
//   The next gnt is possible in the IDLE cycle after RSP.
//  Latency with a zero-wait slave (bvalid/rvalid registered one cycle after handshake):
//   gnt@0, AW/W or AR handshake @1, B or R handshake @2, rvalid_o @3.
//  m_awaddr=m_araddr=latched addr, full 32 bits, no alignment change. m_wstrb=latched be.
//   be=0 is still issued.
//  req_i asserted while busy is ignored until IDLE; the requester holds req_i.
//  Ready signals arriving while the matching valid is 0 are ignored.
// CONFIGURATION
//  AXIL_MST_ADDR_CHECK_EN defined:
//   In IDLE, when (addr_i & ADDR_MASK) != ADDR_BASE, the request is still granted but no AXI traffic is issued.
//   FSM goes straight to RSP with err_o=1, rdata_o=0; rvalid_o 1 cycle after gnt.
//  Not defined: every address is forwarded; ADDR_BASE/ADDR_MASK are unused.
// TESTING
//  Write addr=0x2000_0004 data=0x0000_A5A5 be=4'hF, slave always ready, bresp=0
//   -> awaddr/wdata/wstrb match; rvalid_o @ cycle 3; err_o=0.
//  Read addr=0x2000_0000, slave returns 0x0000_1234 rresp=0 after 4 wait cycles on arready
//   -> arvalid held stable 5 cycles; rdata_o=0x0000_1234.
//  Write with wready 2 cycles before awready, then AW/W same-cycle case
//   -> each valid drops only after its own handshake; exactly one B handshake.
//  Read with rresp=2'b10 -> err_o=1, rdata_o=slave data; back-to-back reads with req_i held
//   -> second gnt in the IDLE cycle after RSP.
//  Assert rst in WB with bvalid pending -> all outputs 0 in the same cycle; no rvalid_o;
//   the next request completes normally.
//  With AXIL_MST_ADDR_CHECK_EN: addr=0x1000_0000 -> no AW/AR valid, rvalid_o=1 err_o=1 rdata_o=0 one cycle after gnt.

Source files
------------

// File: rtl/obi_axil_master.sv
// OBI data port to AXI4-Lite master bridge, one outstanding transaction.
// Optional address window check: define AXIL_MST_ADDR_CHECK_EN.
module obi_axil_master #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h2000_0000,
    parameter logic [ADDR_W-1:0] ADDR_MASK = 32'hFFFF_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WB,
        S_RA,
        S_RR,
        S_RSP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W/8-1:0]   be_q, be_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        gnt_o     = 1'b0;
        rvalid_o  = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    addr_d    = addr_i;
                    be_d      = be_i;
                    wdata_d   = wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef AXIL_MST_ADDR_CHECK_EN
                    // Out-of-window requests are answered locally with an error.
                    if ((addr_i & ADDR_MASK) != ADDR_BASE) begin
                        state_d = S_RSP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = we_i ? S_WR : S_RA;
                    end
`else
                    state_d = we_i ? S_WR : S_RA;
`endif
                end
            end
            S_WR: begin
                // AW and W complete independently, in either order.
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                aw_done_d = aw_done_q | (m_awvalid & m_awready);
                w_done_d  = w_done_q | (m_wvalid & m_wready);
                if (aw_done_d && w_done_d) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    err_d   = (m_bresp != 2'b00);
                    rdata_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RA: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = S_RR;
                end
            end
            S_RR: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    err_d   = (m_rresp != 2'b00);
                    rdata_d = m_rdata;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                rvalid_o = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = be_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_obi_axil_master.sv
// Randomized OBI transactions against a behavioural AXI-Lite slave with
// transaction-level expectations (handshake counts, latency, response data).
module tb_obi_axil_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, gnt_o, we_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  be_i;
    logic        rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready;
    logic        m_rvalid, m_rready;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always #5 clk = ~clk;

    obi_axil_master dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic slave_quiet();
        m_awready = 1'($urandom_range(0, 1));
        m_wready  = 1'($urandom_range(0, 1));
        m_arready = 1'($urandom_range(0, 1));
        m_bvalid  = 1'b0;
        m_rvalid  = 1'b0;
        m_bresp   = 2'($urandom);
        m_rresp   = 2'($urandom);
        m_rdata   = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_i = 1'b0;
            slave_quiet();
            #1;
            chk("gnt_idle", 32'(gnt_o), 0);
            chk("rvalid_idle", 32'(rvalid_o), 0);
        end
    endtask

    task automatic run_txn(
        input logic we, input logic [31:0] addr, input logic [3:0] be,
        input logic [31:0] wd, input int aw_dly, input int w_dly,
        input int ar_dly, input int r_dly, input logic [1:0] resp,
        input logic [31:0] sdata, input bit hold, input int rst_at);
        int          k, aw_c, w_c, ar_c;
        int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
        int          rsp_k, b_go, r_go, exp_k;
        bit          bad, done, wr, rd, p_aw, p_w, p_ar;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [31:0] c_awaddr, c_wdata, c_araddr;
        logic [3:0]  p_wstrb, c_wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        bad = 1'b0;
`ifdef AXIL_MST_ADDR_CHECK_EN
        bad = (addr & 32'hFFFF_0000) != 32'h2000_0000;
`endif
        wr = we && !bad;
        rd = !we && !bad;
        k = 0; aw_c = 0; w_c = 0; ar_c = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        rsp_k = -100; b_go = 1000; r_go = 1000;
        done = 0; p_aw = 0; p_w = 0; p_ar = 0;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
        c_awaddr = '0; c_wdata = '0; c_araddr = '0; c_wstrb = '0;

        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
        slave_quiet();
        #1;
        chk("gnt", 32'(gnt_o), 1);
        chk("rvalid_at_gnt", 32'(rvalid_o), 0);
        chk("rdata_hold", rdata_o, last_rdata);
        chk("err_hold", 32'(err_o), 32'(last_err));

        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            req_i = hold;
            if (!hold) begin
                addr_i = $urandom; wdata_i = $urandom;
                be_i = 4'($urandom); we_i = 1'($urandom);
            end
            m_awready = m_awvalid ? (aw_c >= aw_dly) : 1'($urandom_range(0, 1));
            m_wready  = m_wvalid ? (w_c >= w_dly) : 1'($urandom_range(0, 1));
            m_arready = m_arvalid ? (ar_c >= ar_dly) : 1'($urandom_range(0, 1));
            m_bvalid  = (b_hs == 0) && (k >= b_go);
            m_bresp   = m_bvalid ? resp : 2'($urandom);
            m_rvalid  = (r_hs == 0) && (k >= r_go);
            m_rresp   = m_rvalid ? resp : 2'($urandom);
            m_rdata   = m_rvalid ? sdata : $urandom;
            #1;
            if (k == rst_at) begin
                chk("bready_pre_rst", 32'(m_bready), 1);
                req_i = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_ctrl", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid,
                                     m_rready, rvalid_o, err_o, gnt_o}), 0);
                chk("rst_rdata", rdata_o, 0);
                chk("rst_awaddr", m_awaddr, 0);
                chk("rst_wdata", {m_wdata[31:4], m_wstrb}, 0);
                @(negedge clk);
                rst = 1'b0;
                slave_quiet();
                last_rdata = '0;
                last_err = 1'b0;
                return;
            end
            chk("gnt_busy", 32'(gnt_o), 0);
            if (p_aw) begin
                chk("aw_held", 32'(m_awvalid), 1);
                chk("awaddr_stable", m_awaddr, p_awaddr);
            end
            if (p_w) begin
                chk("w_held", 32'(m_wvalid), 1);
                chk("wdata_stable", m_wdata, p_wdata);
                chk("wstrb_stable", 32'(m_wstrb), 32'(p_wstrb));
            end
            if (p_ar) begin
                chk("ar_held", 32'(m_arvalid), 1);
                chk("araddr_stable", m_araddr, p_araddr);
            end
            if (m_awvalid) begin
                aw_c++;
                if (m_awready) begin aw_hs++; c_awaddr = m_awaddr; end
            end
            if (m_wvalid) begin
                w_c++;
                if (m_wready) begin w_hs++; c_wdata = m_wdata; c_wstrb = m_wstrb; end
            end
            if (m_arvalid) begin
                ar_c++;
                if (m_arready) begin
                    ar_hs++; c_araddr = m_araddr;
                    if (r_go == 1000) r_go = k + r_dly;
                end
            end
            // slave answers r_dly cycles after the later of AW and W
            if (aw_hs > 0 && w_hs > 0 && b_go == 1000) b_go = k + r_dly;
            if (m_bvalid && m_bready) begin b_hs++; rsp_k = k; end
            if (m_rvalid && m_rready) begin r_hs++; rsp_k = k; end
            p_aw = m_awvalid && !m_awready; p_awaddr = m_awaddr;
            p_w  = m_wvalid && !m_wready;   p_wdata = m_wdata; p_wstrb = m_wstrb;
            p_ar = m_arvalid && !m_arready; p_araddr = m_araddr;
            if (rvalid_o) begin
                done = 1;
                exp_k = bad ? 1 : rsp_k + 1;
                exp_rdata = rd ? sdata : 32'h0;
                exp_err = bad ? 1'b1 : (resp != 2'b00);
                chk("rsp_latency", k, exp_k);
                if (!bad && aw_dly == 0 && w_dly == 0 && ar_dly == 0 && r_dly == 1)
                    chk("zero_wait_lat", k, 3);
                chk("rdata", rdata_o, exp_rdata);
                chk("err", 32'(err_o), 32'(exp_err));
                last_rdata = exp_rdata;
                last_err = exp_err;
            end
        end
        if (!done) chk("rsp_timeout", 0, 1);
        chk("aw_count", aw_hs, 32'(wr));
        chk("w_count", w_hs, 32'(wr));
        chk("b_count", b_hs, 32'(wr));
        chk("ar_count", ar_hs, 32'(rd));
        chk("r_count", r_hs, 32'(rd));
        if (wr) begin
            chk("awaddr", c_awaddr, addr);
            chk("wdata", c_wdata, wd);
            chk("wstrb", 32'(c_wstrb), 32'(be));
            chk("aw_cycles", aw_c, aw_dly + 1);
            chk("w_cycles", w_c, w_dly + 1);
        end
        if (rd) begin
            chk("araddr", c_araddr, addr);
            chk("ar_cycles", ar_c, ar_dly + 1);
        end
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        slave_quiet();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("init_ctrl", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid,
                              m_rready, rvalid_o, err_o, gnt_o}), 0);
        chk("init_rdata", rdata_o, 0);
        chk("init_addr", m_awaddr | m_araddr, 0);
        @(negedge clk);
        rst = 1'b0;

        run_txn(1, 32'h2000_0004, 4'hF, 32'h0000_A5A5, 0, 0, 0, 1, 2'b00, 0, 0, -1);
        run_txn(0, 32'h2000_0000, 4'hF, 0, 0, 0, 4, 1, 2'b00, 32'h0000_1234, 0, -1);
        idle_cycles(2);
        run_txn(1, 32'h2000_0010, 4'h3, 32'hDEAD_BEEF, 2, 0, 0, 1, 2'b00, 0, 0, -1);
        run_txn(1, 32'h2000_0020, 4'h0, 32'h1111_2222, 1, 1, 0, 2, 2'b01, 0, 0, -1);
        run_txn(0, 32'h2000_0030, 4'hF, 0, 0, 0, 0, 1, 2'b10, 32'hCAFE_F00D, 1, -1);
        run_txn(0, 32'h2000_0034, 4'hF, 0, 0, 0, 1, 1, 2'b00, 32'h0000_5555, 1, -1);
        run_txn(0, 32'h2000_0038, 4'hF, 0, 0, 0, 0, 2, 2'b00, 32'h0BAD_0001, 0, -1);
        idle_cycles(1);
        run_txn(1, 32'h2000_0040, 4'hF, 32'h0000_0077, 0, 0, 0, 1, 2'b00, 0, 0, 2);
        run_txn(1, 32'h2000_0044, 4'hC, 32'h1234_5678, 0, 0, 0, 1, 2'b00, 0, 0, -1);
`ifdef AXIL_MST_ADDR_CHECK_EN
        run_txn(0, 32'h1000_0000, 4'hF, 0, 0, 0, 0, 1, 2'b00, 32'h7777_7777, 0, -1);
        run_txn(1, 32'h1000_0000, 4'hF, 32'h1, 0, 0, 0, 1, 2'b00, 0, 0, -1);
`endif

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
`ifdef AXIL_MST_ADDR_CHECK_EN
            if ($urandom_range(0, 3) != 0) a = {16'h2000, a[15:0]};
`endif
            run_txn(1'($urandom), a, 4'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(1, 3),
                    2'($urandom), $urandom, 1'($urandom), -1);
            idle_cycles($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
